// File: rtl/nibble_bus_arbiter_if.sv
// Requester-side and external-bus signals of the nibble bus arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface nibble_bus_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              busy;

    modport slave (
        input  req, addr0, addr1, bus_data,
        output gnt, rvalid, rdata, bus_addr, busy
    );

    modport master (
        output req, addr0, addr1, bus_data,
        input  gnt, rvalid, rdata, bus_addr, busy
    );
endinterface

// File: rtl/nibble_bus_arbiter.sv
// Round-robin arbiter sharing one external nibble memory bus between two readers.
// Each read is: grant in IDLE, address held for WAIT_CYCLES, data capture, one-cycle rvalid.
module nibble_bus_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nibble_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_owner;
    logic              r_lastOwner;
    logic [3:0]        r_wcnt;
    logic [ADDR_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rvalid;
    logic              w_winner;
    logic              w_start;
    logic              w_capture;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        w_winner = ~r_lastOwner;
        case (bus.req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            default: w_winner = ~r_lastOwner;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        bus.gnt     = 2'b00;
        case (r_state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    w_start     = 1'b1;
                    w_nextState = ACCESS;
                    bus.gnt     = reset_n ? {w_winner, ~w_winner} : 2'b00;
                end
            end
            ACCESS: begin
                if (r_wcnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= 1'b0;
            r_lastOwner <= 1'b1;
            r_wcnt      <= 4'd0;
            r_busAddr   <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 2'b00;
        end else begin
            r_rvalid <= 2'b00;
            if (w_start) begin
                r_busAddr   <= w_winner ? bus.addr1 : bus.addr0;
                r_owner     <= w_winner;
                r_lastOwner <= w_winner;
                r_wcnt      <= WAIT_INIT;
            end
            if (r_state == ACCESS && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_capture) begin
                r_rdata  <= bus.bus_data;
                r_rvalid <= {r_owner, ~r_owner};
            end
        end
    end

    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = r_rdata;
    assign bus.bus_addr = r_busAddr;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Scoreboard bench: a transaction-level arbiter model predicts grants and read returns,
// a separate monitor pops expected returns when rvalid shows up. A second instance covers WAIT_CYCLES=3.
module tb_nibble_bus_arbiter;
    localparam int W0 = 1;

    typedef struct {
        bit         port;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rstN0;
    logic rstN3;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sbQ[$];

    nibble_bus_arbiter_if #(.ADDR_W(4), .DATA_W(4)) if0 ();
    nibble_bus_arbiter_if #(.ADDR_W(4), .DATA_W(4)) if3 ();

    nibble_bus_arbiter #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(W0)) u0 (
        .clk     (clk),
        .reset_n (rstN0),
        .bus     (if0)
    );

    nibble_bus_arbiter #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(3)) u3 (
        .clk     (clk),
        .reset_n (rstN3),
        .bus     (if3)
    );

    // Memory behind the main instance returns address plus one.
    assign if0.bus_data = if0.bus_addr + 4'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] a1);
        @(posedge clk);
        #2;
        if0.req   = r;
        if0.addr0 = a0;
        if0.addr1 = a1;
    endtask

    // Reference model: the bus is free again W0+2 cycles after a grant; ties alternate.
    bit         mLastOwner = 1'b1;
    int         mNextFree  = 0;
    int         mGrantCyc  = 0;
    logic [3:0] mCurAddr   = 4'd0;

    always @(negedge clk) begin
        logic [1:0] expGnt;
        logic [3:0] a;
        bit         win;
        if (!rstN0) begin
            sbQ.delete();
            mLastOwner = 1'b1;
            mNextFree  = 0;
            mGrantCyc  = 0;
            mCurAddr   = 4'd0;
            checkOutput("reset_gnt", {30'd0, if0.gnt}, 32'd0);
            checkOutput("reset_rvalid", {30'd0, if0.rvalid}, 32'd0);
            checkOutput("reset_busy", {31'd0, if0.busy}, 32'd0);
            checkOutput("reset_bus_addr", {28'd0, if0.bus_addr}, 32'd0);
            checkOutput("reset_rdata", {28'd0, if0.rdata}, 32'd0);
        end else begin
            expGnt = 2'b00;
            if (cyc >= mNextFree && if0.req != 2'b00) begin
                win        = (if0.req == 2'b11) ? ~mLastOwner : if0.req[1];
                expGnt     = win ? 2'b10 : 2'b01;
                a          = win ? if0.addr1 : if0.addr0;
                sbQ.push_back('{win, 4'(a + 4'd1), cyc + W0 + 1});
                mLastOwner = win;
                mNextFree  = cyc + W0 + 2;
                mGrantCyc  = cyc;
                mCurAddr   = a;
            end
            checkOutput("gnt", {30'd0, if0.gnt}, {30'd0, expGnt});
            checkOutput("busy", {31'd0, if0.busy},
                        {31'd0, (cyc > mGrantCyc && cyc < mNextFree)});
            if (cyc != mGrantCyc) begin
                checkOutput("bus_addr", {28'd0, if0.bus_addr}, {28'd0, mCurAddr});
            end
        end
    end

    // Monitor: every rvalid must match the oldest outstanding prediction.
    logic [3:0] monLastData = 4'd0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstN0) begin
            monLastData = 4'd0;
        end else if (if0.rvalid != 2'b00) begin
            if (sbQ.size() == 0) begin
                checkOutput("rvalid_unexpected", {30'd0, if0.rvalid}, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("rvalid_owner", {30'd0, if0.rvalid}, e.port ? 32'd2 : 32'd1);
                checkOutput("rvalid_cycle", cyc, e.cyc);
                checkOutput("rdata", {28'd0, if0.rdata}, {28'd0, e.data});
                monLastData = e.data;
            end
        end else begin
            checkOutput("rdata_hold", {28'd0, if0.rdata}, {28'd0, monLastData});
            if (sbQ.size() != 0 && sbQ[0].cyc < cyc) begin
                checkOutput("rvalid_missing", cyc, sbQ[0].cyc);
                void'(sbQ.pop_front());
            end
        end
    end

    initial begin
        bit seen;
        logic [3:0] prevRd;
        logic [3:0] a;
        logic [3:0] sv;
        errors    = 0;
        checks    = 0;
        rstN0     = 1'b0;
        rstN3     = 1'b0;
        if0.req   = 2'b11;
        if0.addr0 = 4'd0;
        if0.addr1 = 4'd0;
        if3.req   = 2'b00;
        if3.addr0 = 4'd0;
        if3.addr1 = 4'd0;
        if3.bus_data = 4'd9;
        fork
            begin
                repeat (2) @(posedge clk);
                #2;
                rstN0 = 1'b1;
                if0.addr0 = 4'd2;
                if0.addr1 = 4'd5;
                repeat (12) applyStimulus(2'b11, 4'd2, 4'd5);
                repeat (4) applyStimulus(2'b00, 4'd0, 4'd0);

                applyStimulus(2'b01, 4'd3, 4'd0);
                seen = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    seen = if0.gnt[0];
                end
                if (!seen) checkOutput("single_gnt_timeout", 32'd0, 32'd1);
                repeat (4) applyStimulus(2'b00, 4'd0, 4'd0);

                repeat (10) applyStimulus(2'b10, 4'd0, 4'd14);
                repeat (4) applyStimulus(2'b00, 4'd0, 4'd0);

                applyStimulus(2'b01, 4'd4, 4'd0);
                @(negedge clk);
                @(posedge clk);
                #2;
                if0.req = 2'b00;
                rstN0   = 1'b0;
                @(posedge clk);
                #2;
                rstN0 = 1'b1;
                repeat (4) applyStimulus(2'b00, 4'd0, 4'd0);

                for (int i = 0; i < 3000; i++) begin
                    if ($urandom_range(0, 199) == 0) begin
                        @(posedge clk);
                        #2;
                        rstN0 = 1'b0;
                        @(posedge clk);
                        #2;
                        rstN0 = 1'b1;
                    end
                    applyStimulus(2'($urandom), 4'($urandom), 4'($urandom));
                end
                repeat (8) applyStimulus(2'b00, 4'd0, 4'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                rstN3  = 1'b1;
                prevRd = 4'd0;
                for (int n = 0; n < 2; n++) begin
                    a  = (n == 0) ? 4'd0 : 4'd10;
                    sv = (n == 0) ? 4'd7 : 4'd12;
                    @(posedge clk);
                    #2;
                    if3.req      = 2'b01;
                    if3.addr0    = a;
                    if3.bus_data = 4'd9;
                    @(negedge clk);
                    checkOutput("w3_gnt", {30'd0, if3.gnt}, 32'd1);
                    checkOutput("w3_busy_idle", {31'd0, if3.busy}, 32'd0);
                    for (int k = 1; k <= 5; k++) begin
                        @(posedge clk);
                        #2;
                        if3.req      = 2'b00;
                        if3.bus_data = (k == 3) ? sv : 4'd9;
                        @(negedge clk);
                        if (k <= 4) begin
                            checkOutput("w3_bus_addr", {28'd0, if3.bus_addr}, {28'd0, a});
                            checkOutput("w3_busy", {31'd0, if3.busy}, 32'd1);
                            checkOutput("w3_rvalid", {30'd0, if3.rvalid}, (k == 4) ? 32'd1 : 32'd0);
                            checkOutput("w3_rdata", {28'd0, if3.rdata}, {28'd0, (k == 4) ? sv : prevRd});
                        end else begin
                            checkOutput("w3_busy_end", {31'd0, if3.busy}, 32'd0);
                            checkOutput("w3_rvalid_end", {30'd0, if3.rvalid}, 32'd0);
                        end
                    end
                    prevRd = sv;
                end
            end
        join
        checkOutput("sb_drain", sbQ.size(), 32'd0);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_bus_arbiter.md
# nibble_bus_arbiter

Shares the single 4-bit external nibble memory bus (4-bit address out, 4-bit data in) between two on-chip requesters: the CPU instruction/operand fetch (port 0) and a loader/debug port (port 1). It sequences each read as address-drive, a fixed number of wait cycles, then data capture, and returns the nibble to the winning requester. Arbitration is round-robin between the two ports. The block sits between the CPU core and the io_out/io_in pins of the tile.

## Interface

- ADDR_W, default 4: external address width.
- DATA_W, default 4: external data width.
- WAIT_CYCLES, default 1: cycles the address is held before data is sampled; legal range 1..15.

- clk  in  1  rising-edge clock (io_in[0] at tile level).
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- req  in  2  per-port read request; level, held until gnt seen.
- addr0  in  ADDR_W  port 0 read address, valid while req[0]=1.
- addr1  in  ADDR_W  port 1 read address, valid while req[1]=1.
- gnt  out  2  one-hot; combinational accept strobe, high only in IDLE for the winner.
- rvalid  out  2  one-hot; registered one-cycle pulse, rdata valid for that owner.
- rdata  out  DATA_W  captured nibble; holds until the next capture.
- bus_addr  out  ADDR_W  registered external address (to io_out[3:0]).
- bus_data  in  DATA_W  external read data (from io_in[7:4]).
- busy  out  1  state != IDLE.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if no req, stay. If exactly one req bit set, that port wins. If both set, winner = port not equal to last_owner. gnt[winner]=1 this cycle. On the edge: bus_addr <= winner's addr, owner <= winner, last_owner <= winner, wcnt <= WAIT_CYCLES-1, state -> ACCESS.
- ACCESS: bus_addr held. If wcnt != 0, decrement. If wcnt == 0: on the edge rdata <= bus_data, state -> DONE. bus_data is ignored in every other cycle.
- DONE: rvalid[owner]=1 for exactly this cycle; gnt=0; next edge -> IDLE.
- req bits are ignored outside IDLE. A port still asserting req when IDLE is re-entered is treated as a new request.
- bus_addr keeps the last transaction's address while IDLE.
- Counter width is 4 bits; WAIT_CYCLES outside 1..15 is unsupported.

## Timing

- Reset (async, reset_n=0): state=IDLE, bus_addr=0, rdata=0, owner=0, last_owner=1 (port 0 wins the first tie), wcnt=0. Outputs gnt=0, rvalid=0, busy=0 while reset_n is low.
- gnt is combinational in the IDLE cycle, T. bus_addr changes at the end of T.
- Data is sampled at the end of cycle T+WAIT_CYCLES. rvalid and the new rdata appear in cycle T+WAIT_CYCLES+1.
- Transaction occupancy is WAIT_CYCLES+2 cycles. The next gnt comes no earlier than T+WAIT_CYCLES+2.
- Back-to-back, with both ports requesting continuously, grants alternate 0,1,0,1. A lone requester receives every grant.
- Reset asserted mid-ACCESS or mid-DONE: the transaction is aborted. No rvalid is emitted after release, and the FSM restarts in IDLE with reset values.
- Requester drops req before being granted: no transaction, no state change.

## Test plan

- Reset: hold reset_n=0 for 2 cycles with req=2'b11. Required: gnt=0, rvalid=0, busy=0, bus_addr=0, rdata=0. After release, the first grant goes to port 0.
- Single read, WAIT_CYCLES=1, memory model bus_data=bus_addr+1 mod 16. req[0]=1, addr0=3. Required: gnt[0] in cycle T, bus_addr=3 from T+1, rvalid[0] in T+2 with rdata=4, busy high for T+1..T+2.
- Tie: req=2'b11, addr0=2, addr1=5, both held. Required: reads 2,5,2,5 to ports 0,1,0,1, with rdata 3,6,3,6 on the matching rvalid bits, and gnt spaced 3 cycles apart.
- Lone port 1: req[1] held, addr1=14. Required: gnt[1] every 3 cycles, rvalid[1] with rdata=15 each time, and gnt[0] and rvalid[0] never asserted.
- Abort: start a port-0 read of addr 4. Pull reset_n low in the ACCESS cycle for 1 cycle. Required: outputs at reset values immediately, no rvalid afterward, and the FSM in IDLE after release.
- WAIT_CYCLES=3: model drives bus_data=9 except in the sampling cycle, where it drives 7; port 0 reads addr 0. Required: rvalid[0] at T+4 with rdata=7, and bus_addr stable from T+1 through T+4.
